// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: synchronizes a foreign-domain Gray count, decodes it to binary and
// reports per-cycle advance, step pulses and illegal multi-bit Gray transitions.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta,
    output logic             step,
    output logic             err,
    output logic             err_sticky,
    output logic             primed
);
    localparam int CW = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gray_prev;
    logic [WIDTH-1:0] bin_next;
    logic [CW-1:0]    prime_cnt;
    logic             err_next;

    assign gray_sync = sync_q[SYNC_STAGES-1];
    assign err_next  = $countones(gray_sync ^ gray_prev) > 1;

    // Each binary bit is the parity of all Gray bits at or above it.
    always_comb begin
        bin_next = '0;
        for (int i = 0; i < WIDTH; i++) bin_next[i] = ^(gray_sync >> i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // primed rises on the edge the counter saturates; outputs below are masked by its pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt  <= '0;
            primed     <= 1'b0;
            gray_prev  <= '0;
            bin_out    <= '0;
            delta      <= '0;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prime_cnt  <= (prime_cnt == CW'(SYNC_STAGES + 1)) ? prime_cnt : prime_cnt + 1'b1;
            primed     <= primed | (prime_cnt >= CW'(SYNC_STAGES));
            gray_prev  <= gray_sync;
            bin_out    <= bin_next;
            delta      <= primed ? bin_next - bin_out : '0;
            step       <= primed && (bin_next != bin_out);
            err        <= primed && err_next;
            err_sticky <= primed && (err_next || (err_sticky && !clr_err));
        end
    end
endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder: directed and random stimulus checked against an edge-indexed
// history model of the synchronizer/decoder.
module tb_gray_sync_decoder;
    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         clr_err = 1'b0;
    logic [W-1:0] gray_sync, bin_out, delta;
    logic         step, err, err_sticky, primed;

    int checks = 0;
    int errors = 0;

    // Model: values driven before each edge since reset release, indexed by edge number.
    logic [W-1:0] in_h [0:4095];
    bit           st_h [0:4095];
    int           e = 0;

    gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
        .gray_sync(gray_sync), .bin_out(bin_out), .delta(delta), .step(step),
        .err(err), .err_sticky(err_sticky), .primed(primed)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dec(input logic [W-1:0] g);
        logic [W-1:0] b = g;
        for (int s = 1; s < W; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic logic [W-1:0] gs_m(input int k);
        return (k < S) ? '0 : in_h[k-S+1];
    endfunction

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gray_sync"}, 32'(gray_sync), 0);
        chk({tag, "_bin_out"}, 32'(bin_out), 0);
        chk({tag, "_delta"}, 32'(delta), 0);
        chk({tag, "_step"}, 32'(step), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_err_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_primed"}, 32'(primed), 0);
    endtask

    task automatic tick(input logic [W-1:0] g, input logic c);
        bit           pp, x_err;
        logic [W-1:0] x_delta;
        gray_in = g;
        clr_err = c;
        @(posedge clk);
        e++;
        in_h[e] = g;
        pp      = (e - 1) >= S + 1;
        x_err   = pp && ($countones(gs_m(e-1) ^ gs_m(e-2)) > 1);
        x_delta = pp ? dec(gs_m(e-1)) - dec(gs_m(e-2)) : '0;
        st_h[e] = pp && (x_err || (st_h[e-1] && !c));
        #1;
        chk("gray_sync", 32'(gray_sync), 32'(gs_m(e)));
        chk("bin_out", 32'(bin_out), 32'(dec(gs_m(e-1))));
        chk("delta", 32'(delta), 32'(x_delta));
        chk("step", 32'(step), 32'(x_delta != 0));
        chk("err", 32'(err), 32'(x_err));
        chk("err_sticky", 32'(err_sticky), 32'(st_h[e]));
        chk("primed", 32'(primed), 32'(e >= S + 1));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        st_h[0] = 1'b0;
    endtask

    initial begin
        logic [W-1:0] src;
        gray_in = 4'b0101;
        repeat (3) @(posedge clk);
        #1 chk_zero("in_reset");
        release_reset();
        repeat (3) tick(4'b0101, 1'b0);
        chk("release_bin_6", 32'(bin_out), 6);
        chk("release_primed", 32'(primed), 1);
        chk("release_delta_0", 32'(delta), 0);
        repeat (4) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        chk("inc_gray_sync", 32'(gray_sync), 1);
        tick(4'b0001, 1'b0);
        chk("inc_bin", 32'(bin_out), 1);
        chk("inc_delta", 32'(delta), 1);
        chk("inc_step", 32'(step), 1);
        tick(4'b0001, 1'b0);
        chk("inc_step_drop", 32'(step), 0);
        repeat (3) tick(4'b1000, 1'b0);
        chk("wrap_pre_bin", 32'(bin_out), 15);
        repeat (3) tick(4'b0000, 1'b1);
        chk("wrap_bin", 32'(bin_out), 0);
        chk("wrap_delta", 32'(delta), 1);
        chk("wrap_step", 32'(step), 1);
        chk("wrap_err", 32'(err), 0);
        repeat (3) tick(4'b0011, 1'b0);
        chk("jump_err", 32'(err), 1);
        chk("jump_delta", 32'(delta), 2);
        tick(4'b0011, 1'b0);
        chk("jump_err_pulse", 32'(err), 0);
        chk("jump_sticky", 32'(err_sticky), 1);
        tick(4'b0011, 1'b1);
        chk("clr_sticky", 32'(err_sticky), 0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        chk("set_wins_err", 32'(err), 1);
        chk("set_wins_sticky", 32'(err_sticky), 1);
        repeat (3) tick(4'b1101, 1'b0);
        chk("pre_reset_bin_9", 32'(bin_out), 9);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk);
        release_reset();
        tick(4'b0110, 1'b0);
        tick(4'b0101, 1'b0);
        tick(4'b1010, 1'b0);
        // Random phase: mostly legal advances of 0..3 counts, with occasional arbitrary jumps.
        src = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("rand_reset");
                @(posedge clk);
                release_reset();
            end
            if ($urandom_range(0, 9) == 0) src = W'($urandom);
            else src = src + W'($urandom_range(0, 3));
            tick(to_gray(src), $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 Parameter WIDTH, default 4: width of the Gray-coded count; SHALL be legal for 2 to 32.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops; SHALL be legal for 2 to 4.
REQ-003 clk  input  1  receive-domain clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 gray_in  input  WIDTH  Gray count from a foreign clock domain, asynchronous to clk.
REQ-006 clr_err  input  1  synchronous clear of err_sticky.
REQ-007 gray_sync  output  WIDTH  last synchronizer stage.
REQ-008 bin_out  output  WIDTH  registered binary decode of gray_sync.
REQ-009 delta  output  WIDTH  registered count advance since the previous cycle, modulo 2^WIDTH.
REQ-010 step  output  1  one-cycle pulse; high when the registered delta is nonzero.
REQ-011 err  output  1  one-cycle pulse; high on an illegal multi-bit Gray transition.
REQ-012 err_sticky  output  1  latched err.
REQ-013 primed  output  1  high once the pipeline holds post-reset data.

Function
REQ-014 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; gray_sync is the last stage; no logic between stages.
REQ-015 Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i], for i from WIDTH-2 down to 0.
REQ-016 Each edge: bin_out <= decode(gray_sync); gray_prev <= gray_sync (internal register).
REQ-017 Latency: a gray_in value stable before edge N SHALL appear on gray_sync after edge N+SYNC_STAGES-1 and on bin_out after edge N+SYNC_STAGES.
REQ-018 delta <= decode(gray_sync) - bin_out, computed as WIDTH-bit unsigned subtraction with modulo wrap, registered on the same edge as bin_out.
REQ-019 step <= (decode(gray_sync) != bin_out), registered alongside delta.
REQ-020 err <= (popcount(gray_sync XOR gray_prev) > 1); a 0-bit or 1-bit change SHALL NOT flag an error.
REQ-021 err_sticky: set when err is computed as 1. Else cleared when clr_err=1. Set wins when both occur in the same cycle.
REQ-022 Priming counter: counts from 0 to SYNC_STAGES+1 after reset, then saturates. primed = 1 when the counter reaches SYNC_STAGES+1.
REQ-023 Masking: while primed=0, delta is forced to 0 and step, err and err_sticky are held at 0. bin_out and gray_sync update normally.
REQ-024 Wrap: a transition from all-ones binary to zero SHALL yield delta=1, step=1, err=0.
REQ-025 A source advance of k>1 within one clk cycle SHALL yield delta=k; err follows REQ-020 independently.

Reset
REQ-026 While rst_n=0, all flops SHALL clear asynchronously: synchronizer stages, gray_prev, bin_out, delta, step, err, err_sticky, the priming counter and primed all read 0.
REQ-027 Reset release SHALL be synchronous to clk. Priming restarts from 0 after every reset, including a reset asserted mid-operation.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-028 Hold rst_n=0 with gray_in=0101 -> all outputs 0. Release reset -> bin_out=6 after 3 edges; primed=1; delta=0; step=0; err=0 throughout.
REQ-029 Primed, gray_in changes 0000->0001 before edge N -> gray_sync=0001 after edge N+1; bin_out=1, delta=1, step=1 after edge N+2; step=0 on the following cycle.
REQ-030 Primed, bin_out=15 (gray 1000), gray_in changes to 0000 -> bin_out=0, delta=1, step=1, err=0.
REQ-031 Primed, gray_in jumps 0000->0011 -> err pulses for 1 cycle, err_sticky=1, delta=2. A clr_err pulse -> err_sticky=0 on the next edge. A new error in the same cycle as clr_err -> err_sticky stays 1.
REQ-032 Primed with bin_out=9, assert rst_n mid-cycle -> all outputs 0 without waiting for a clk edge. After release -> primed=0 for 3 edges, and step and err are held at 0 during that time.
